jk_bank_seq: RTL
================

# jk_bank_seq

Command-driven sequencer for a bank of `WIDTH` positive-edge JK flip-flops, one flop per bit. It accepts one command per valid/ready handshake and drives the bank's per-bit J/K inputs for a programmed number of clock cycles. It reads the bank's Q outputs back to compute each step. It sits between a control FSM or register interface and the flop bank, and turns counter, load, clear, invert and shift operations into J/K encodings.

## Interface
- `WIDTH`, default 4: number of flops in the bank (≥2).
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: a command is presented.
- `cmd_ready` out 1: the block can accept a command (IDLE only).
- `cmd_op` in 3: operation; latched on accept.
- `cmd_data` in WIDTH: load value; bit 0 is also the shift serial-in. Latched on accept.
- `cmd_steps` in 8: number of active cycles; latched on accept.
- `abort` in 1: terminates the active command.
- `q_in` in WIDTH: Q feedback from the flop bank.
- `j_out` in WIDTH, direction out: per-bit J to the bank.
- `k_out` in WIDTH, direction out: per-bit K to the bank.
- `busy` out 1: high in RUN and DONE.
- `done` out 1: one-cycle completion pulse.
- `wrap` out 1: counter wrapped during the command. Valid only while `done`=1.
- `aborted` out 1: the command ended by abort. Valid only while `done`=1.

## Operation
- **J/K encoding per bit:** hold 00, reset 01, set 10, toggle 11.
- **Ops, from latched op/data and live `q_in`:**
  - 000 HOLD: all bits 00.
  - 001 UP: bit i toggles iff `q_in[i-1:0]` are all 1 (bit 0 always toggles); otherwise 00.
  - 010 DOWN: bit i toggles iff `q_in[i-1:0]` are all 0 (bit 0 always toggles).
  - 011 LOAD: J=d, K=~d.
  - 100 CLEAR: all bits 01.
  - 101 INVERT: all bits 11.
  - 110 SHL: next[i]=q_in[i-1], next[0]=data[0]; J=next, K=~next.
  - 111 reserved: behaves as HOLD.
- **States:**
  - IDLE: `cmd_ready`=1, J/K=0.
  - RUN: J/K active. `step_cnt` is loaded with `cmd_steps` and decrements each cycle.
  - DONE: one cycle, `done`=1, J/K=0.
- **Transitions:**
  - IDLE→RUN on `cmd_valid`&`cmd_ready` when `cmd_steps`≠0.
  - IDLE→DONE on accept when `cmd_steps`=0. No step occurs.
  - RUN→DONE when `step_cnt`=1 or `abort`=1.
  - DONE→IDLE unconditionally.
- **Wrap:**
  - `wrap` is cleared on accept.
  - It is set on any RUN cycle with UP and `q_in` all-ones, or DOWN and `q_in` all-zeros, unless that cycle is aborted.
- **Abort:**
  - Combinationally forces J/K=00 in the same cycle, so no bank update occurs at that edge.
  - `aborted`=1 in DONE.
  - Abort coinciding with the last step: abort wins and the step does not occur.
  - Abort in IDLE or DONE is ignored.
- `cmd_valid` while busy is ignored and is not queued.
- `cmd_data` is sampled only at accept. Later changes have no effect.
- **Integration:** the bank's active-high reset is driven from `~reset_n`. The block never generates reset on the bank itself.

## Timing
- **Reset:**
  - All outputs go to 0 immediately: `j_out`, `k_out`, `busy`, `done`, `wrap`, `aborted`.
  - State goes to IDLE and `step_cnt` to 0.
  - `cmd_ready`=1 once `reset_n` is high.
- **Reset mid-RUN:** J/K drop to 0 asynchronously. No `done` is produced and the command is lost.
- **J/K drive:**
  - J/K are combinational from state, latched op/data, `q_in` and `abort`.
  - The bank samples them on each RUN-cycle rising edge.
- **Cycle sequence:**
  - Accept at edge E0.
  - Bank updates at edges E1..ES, where S=`cmd_steps`.
  - `done` is high in cycle ES..ES+1.
  - `cmd_ready` returns at ES+1.
- Total occupancy is S+1 cycles, or 1 cycle for S=0.
- Back-to-back commands: the minimum accept-to-accept spacing is S+2 edges.
- The step counter is 8-bit with no wrap, so the maximum is 255 steps.
- **Counter arithmetic:** modulo 2^WIDTH. UP from all-ones yields 0; DOWN from 0 yields all-ones.

## Test plan
- **UP:** reset, bank=0. Issue UP with steps=5. Expect bank=5 after E5, `done` one cycle, `wrap`=0, `cmd_ready` high at E6.
- **DOWN wrap:** LOAD data=1 steps=1, then DOWN steps=3 (WIDTH=4). Expect bank=0→15→14, ending at 14, with `wrap`=1 at `done`.
- **SHL:** LOAD 0xA, then SHL data=1 steps=2. Expect bank 0x5, then 0xB. INVERT steps=1 then gives 0x4.
- **Abort:** UP steps=10 from 0, assert `abort` in the 4th RUN cycle. Expect bank=3, `aborted`=1 with `done`, J/K=0 in the abort cycle.
- **steps=0 and busy:** steps=0 gives `done` in the cycle after accept with the bank unchanged. `cmd_valid` held during RUN causes no second accept until IDLE.
- **Reset mid-operation:** pull `reset_n` low mid-RUN. Expect J/K=0, `busy`=0 and `done`=0 immediately, the bank cleared, and `cmd_ready`=1 after release.

Source files
------------

// File: rtl/jk_bank_seq_if.sv
// Command/feedback bundle between a controller and the JK bank sequencer.
// Latency: n/a (wires only).
// Backpressure: cmd_valid/cmd_ready handshake; cmd_ready is high only when the sequencer is idle.
// Signals: cmd_* command channel, abort, q_in bank feedback, j_out/k_out bank drive,
//          busy/done/wrap/aborted status.
interface jk_bank_seq_if #(
    parameter int WIDTH = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [7:0]       cmd_steps;
    logic             abort;
    logic [WIDTH-1:0] q_in;
    logic [WIDTH-1:0] j_out;
    logic [WIDTH-1:0] k_out;
    logic             busy;
    logic             done;
    logic             wrap;
    logic             aborted;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_steps, abort, q_in,
        input  cmd_ready, j_out, k_out, busy, done, wrap, aborted
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_steps, abort, q_in,
        output cmd_ready, j_out, k_out, busy, done, wrap, aborted
    );
endinterface

// File: rtl/jk_bank_seq.sv
// Sequencer driving per-bit J/K of a JK flop bank for a programmed number of cycles.
// Latency: accept at E0, bank steps at E1..ES, done in the cycle after ES; occupancy S+1 cycles (1 for S=0).
// Backpressure: cmd_ready only in IDLE; commands offered while busy are dropped, not queued.
// Ports: clk, reset_n (async active-low), sif (slave modport of jk_bank_seq_if; its WIDTH must match).
module jk_bank_seq #(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    jk_bank_seq_if.slave sif
);
    localparam logic [2:0] OP_UP   = 3'b001;
    localparam logic [2:0] OP_DOWN = 3'b010;
    localparam logic [2:0] OP_LOAD = 3'b011;
    localparam logic [2:0] OP_CLR  = 3'b100;
    localparam logic [2:0] OP_INV  = 3'b101;
    localparam logic [2:0] OP_SHL  = 3'b110;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] data_q;
    logic [7:0]       step_cnt_q, step_cnt_d;
    logic             wrap_q, wrap_d;
    logic             aborted_q, aborted_d;

    logic             accept;
    logic             run_act;
    logic             wrap_hit;
    logic [WIDTH-1:0] tgl_up, tgl_dn, shl_nxt;
    logic [WIDTH-1:0] j_raw, k_raw;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (sif.cmd_valid) state_d = (sif.cmd_steps == 8'd0) ? S_DONE : S_RUN;
            S_RUN:  if (sif.abort || step_cnt_q == 8'd1) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        sif.cmd_ready = (state_q == S_IDLE) && reset_n;
        sif.busy      = (state_q != S_IDLE);
        sif.done      = (state_q == S_DONE);
        // Abort kills the drive in the same cycle so the bank does not step on that edge.
        run_act       = (state_q == S_RUN) && !sif.abort;
        sif.wrap      = wrap_q && sif.done;
        sif.aborted   = aborted_q && sif.done;
        sif.j_out     = run_act ? j_raw : '0;
        sif.k_out     = run_act ? k_raw : '0;
    end

    assign accept = (state_q == S_IDLE) && sif.cmd_valid;

    // ---------------- J/K encoding from latched op/data and live Q ----------------
    always_comb begin
        logic cu, cd;
        cu     = 1'b1;
        cd     = 1'b1;
        tgl_up = '0;
        tgl_dn = '0;
        // Ripple-carry/borrow masks: bit i toggles when all lower bits are 1 (up) or 0 (down).
        for (int i = 0; i < WIDTH; i++) begin
            tgl_up[i] = cu;
            tgl_dn[i] = cd;
            cu        = cu & sif.q_in[i];
            cd        = cd & ~sif.q_in[i];
        end
        shl_nxt = {sif.q_in[WIDTH-2:0], data_q[0]};
        j_raw   = '0;
        k_raw   = '0;
        case (op_q)
            OP_UP:   begin j_raw = tgl_up;  k_raw = tgl_up;   end
            OP_DOWN: begin j_raw = tgl_dn;  k_raw = tgl_dn;   end
            OP_LOAD: begin j_raw = data_q;  k_raw = ~data_q;  end
            OP_CLR:  begin j_raw = '0;      k_raw = '1;       end
            OP_INV:  begin j_raw = '1;      k_raw = '1;       end
            OP_SHL:  begin j_raw = shl_nxt; k_raw = ~shl_nxt; end
            default: begin j_raw = '0;      k_raw = '0;       end
        endcase
    end

    assign wrap_hit = ((op_q == OP_UP) && (&sif.q_in)) || ((op_q == OP_DOWN) && ~(|sif.q_in));

    // ---------------- datapath next state ----------------
    always_comb begin
        step_cnt_d = step_cnt_q;
        wrap_d     = wrap_q;
        aborted_d  = aborted_q;
        if (accept) begin
            step_cnt_d = sif.cmd_steps;
            wrap_d     = 1'b0;
            aborted_d  = 1'b0;
        end else if (state_q == S_RUN) begin
            step_cnt_d = step_cnt_q - 8'd1;
            if (sif.abort)    aborted_d = 1'b1;
            else if (wrap_hit) wrap_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q       <= 3'b000;
            data_q     <= '0;
            step_cnt_q <= 8'd0;
            wrap_q     <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            if (accept) begin
                op_q   <= sif.cmd_op;
                data_q <= sif.cmd_data;
            end
            step_cnt_q <= step_cnt_d;
            wrap_q     <= wrap_d;
            aborted_q  <= aborted_d;
        end
    end
endmodule
